rpn_eval: RTL and testbench

- Postfix (RPN) expression evaluator that drives the stack block's push/pop interface from the initiator side.
- Accepts a token stream (operands, operators, end marker) through a valid/ready handshake.
- Issues push/pop cycles to an external stack and returns the single final result.
- Sits between a token source (UART/keypad front end) and a stack instance of matching WORD_BITS.

---
 rtl/rpn_eval.sv | 150 +++++++++++++++
 tb/tb_rpn_eval.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_eval.sv
// Postfix expression evaluator: consumes operand/operator/end tokens and drives
// an external stack through push/pop strobes, returning the final result.
module rpn_eval #(
    parameter int WORD_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tok_valid,
    output logic                 tok_ready,
    input  logic                 tok_is_op,
    input  logic                 tok_is_end,
    input  logic [WORD_BITS-1:0] tok_data,
    output logic [WORD_BITS-1:0] result,
    output logic                 result_valid,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic                 push,
    output logic                 pop,
    output logic [WORD_BITS-1:0] push_data,
    input  logic [WORD_BITS-1:0] pop_data,
    input  logic                 empty,
    input  logic                 full
);

    // state   | meaning
    // IDLE    | accepting tokens; operands pushed directly
    // POP_A   | second (deeper) operand popped into A
    // PUSH    | f(A,B) pushed back onto the stack
    // CHECK   | final value popped; stack must now be empty
    // ERR     | sticky error, draining the stack until reset
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP_A = 3'd1;
    localparam logic [2:0] S_PUSH  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]           state, state_nxt;
    logic [WORD_BITS-1:0] a_reg, b_reg, r_reg, alu;
    logic [1:0]           op_reg;
    logic                 ld_a, ld_b, ld_r;
    logic                 err_set;
    logic [1:0]           err_code_nxt;

    always_comb begin
        case (op_reg)
            2'b00:   alu = a_reg + b_reg;
            2'b01:   alu = a_reg - b_reg;
            2'b10:   alu = a_reg & b_reg;
            default: alu = a_reg ^ b_reg;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        tok_ready    = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        push_data    = '0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_r         = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = 2'b00;
        case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid) begin
                    if (tok_is_end || tok_is_op) begin
                        if (empty) begin
                            err_set      = 1'b1;
                            err_code_nxt = 2'b10;
                        end else begin
                            pop  = 1'b1;
                            ld_r = tok_is_end;
                            ld_b = !tok_is_end;
                            state_nxt = tok_is_end ? S_CHECK : S_POP_A;
                        end
                    end else if (full) begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'b01;
                    end else begin
                        push      = 1'b1;
                        push_data = tok_data;
                    end
                end
            end
            S_POP_A: begin
                if (empty) begin
                    err_set      = 1'b1;
                    err_code_nxt = 2'b10;
                end else begin
                    pop       = 1'b1;
                    ld_a      = 1'b1;
                    state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                push      = 1'b1;
                push_data = alu;
                state_nxt = S_IDLE;
            end
            S_CHECK: begin
                if (empty) begin
                    state_nxt = S_IDLE;
                end else begin
                    err_set      = 1'b1;
                    err_code_nxt = 2'b11;
                end
            end
            S_ERR: begin
                pop = !empty;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (err_set) state_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            r_reg        <= '0;
            op_reg       <= 2'b00;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;
            if (ld_b) begin
                b_reg  <= pop_data;
                op_reg <= tok_data[1:0];
            end
            if (ld_a) a_reg <= pop_data;
            if (ld_r) r_reg <= pop_data;
            // err_set only fires outside ERR, so the first error code sticks
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_code_nxt;
            end
            if (state == S_CHECK && empty) begin
                result       <= r_reg;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval with a behavioural 4-deep stack attached.
module tb_rpn_eval;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_is_op = 1'b0;
    logic       tok_is_end = 1'b0;
    logic [3:0] tok_data = 4'h0;
    logic [3:0] result;
    logic       result_valid;
    logic       err;
    logic [1:0] err_code;
    logic       push, pop;
    logic [3:0] push_data;
    logic [3:0] pop_data;
    logic       empty, full;

    int tests = 0;
    int fails = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int both_cnt = 0;
    int p0, q0;

    logic [3:0] mem [4];
    logic [2:0] sp;
    logic [1:0] top_idx;

    rpn_eval #(.WORD_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_is_op(tok_is_op), .tok_is_end(tok_is_end), .tok_data(tok_data),
        .result(result), .result_valid(result_valid),
        .err(err), .err_code(err_code),
        .push(push), .pop(pop), .push_data(push_data),
        .pop_data(pop_data), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    assign top_idx  = sp[1:0] - 2'd1;
    assign empty    = (sp == 3'd0);
    assign full     = (sp == 3'd4);
    assign pop_data = empty ? 4'h0 : mem[top_idx];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 3'd0;
        end else if (push && !full) begin
            mem[sp[1:0]] <= push_data;
            sp <= sp + 3'd1;
        end else if (pop && !empty) begin
            sp <= sp - 3'd1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            if (push) push_cnt <= push_cnt + 1;
            if (pop) pop_cnt <= pop_cnt + 1;
            if (push && pop) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tok_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic is_op, input logic is_end, input logic [3:0] d);
        int n = 0;
        tok_is_op  = is_op;
        tok_is_end = is_end;
        tok_data   = d;
        tok_valid  = 1'b1;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) begin
            tests++;
            fails++;
            $error("FAIL tok_ready_timeout observed=0 expected=1");
        end
        @(negedge clk);
        tok_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [3:0] exp);
        int n = 0;
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, result_valid, 1'b1);
        check(tag, result, exp);
        @(negedge clk);
        check({tag, "_pulse"}, result_valid, 1'b0);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_ready"}, tok_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        do_reset();
        check("rst_ready", tok_ready, 1'b1);
        check("rst_push", push, 1'b0);
        check("rst_pop", pop, 1'b0);
        check("rst_push_data", push_data, 4'h0);
        check("rst_result", result, 4'h0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_empty", empty, 1'b1);

        // 2: 3 4 + END
        send(1'b0, 1'b0, 4'd3);
        send(1'b0, 1'b0, 4'd4);
        check("t2_pushes", push_cnt, 2);
        send(1'b1, 1'b0, 4'd0);
        check("t2_ready_popa", tok_ready, 1'b0);
        @(negedge clk);
        check("t2_ready_push", tok_ready, 1'b0);
        check("t2_push", push, 1'b1);
        check("t2_pop_in_push", pop, 1'b0);
        check("t2_sum", push_data, 4'h7);
        @(negedge clk);
        check("t2_ready_back", tok_ready, 1'b1);
        send(1'b0, 1'b1, 4'd0);
        wait_result("t2_result", 4'h7);

        // 3: subtract, wrapping add, xor
        send(1'b0, 1'b0, 4'd2);
        send(1'b0, 1'b0, 4'd3);
        send(1'b1, 1'b0, 4'd1);
        send(1'b0, 1'b1, 4'd0);
        wait_result("t3_sub", 4'hF);
        send(1'b0, 1'b0, 4'd9);
        send(1'b0, 1'b0, 4'd9);
        send(1'b1, 1'b0, 4'd0);
        send(1'b0, 1'b1, 4'd0);
        wait_result("t3_wrap", 4'h2);
        send(1'b0, 1'b0, 4'd12);
        send(1'b0, 1'b0, 4'd10);
        send(1'b1, 1'b0, 4'd3);
        send(1'b0, 1'b1, 4'd0);
        wait_result("t3_xor", 4'h6);
        check("t3_err", err, 1'b0);

        // 4: overflow on fifth operand
        p0 = push_cnt;
        send(1'b0, 1'b0, 4'd1);
        send(1'b0, 1'b0, 4'd3);
        send(1'b0, 1'b0, 4'd5);
        send(1'b0, 1'b0, 4'd7);
        check("t4_full", full, 1'b1);
        send(1'b0, 1'b0, 4'd9);
        q0 = pop_cnt;
        check("t4_err", err, 1'b1);
        check("t4_code", err_code, 2'b01);
        repeat (6) @(negedge clk);
        check("t4_pushes", push_cnt - p0, 4);
        check("t4_drain_pops", pop_cnt - q0, 4);
        check("t4_empty", empty, 1'b1);
        check("t4_ready", tok_ready, 1'b0);
        check("t4_pop_idle", pop, 1'b0);
        check("t4_code_held", err_code, 2'b01);

        // 5a: underflow at POP_A
        do_reset();
        check("t5_rst_err", err, 1'b0);
        send(1'b0, 1'b0, 4'd5);
        send(1'b1, 1'b0, 4'd2);
        @(negedge clk);
        check("t5a_err", err, 1'b1);
        check("t5a_code", err_code, 2'b10);
        check("t5a_empty", empty, 1'b1);
        check("t5a_ready", tok_ready, 1'b0);

        // 5b: leftover operand at END
        do_reset();
        q0 = pop_cnt;
        send(1'b0, 1'b0, 4'd1);
        send(1'b0, 1'b0, 4'd2);
        send(1'b0, 1'b1, 4'd0);
        repeat (3) @(negedge clk);
        check("t5b_err", err, 1'b1);
        check("t5b_code", err_code, 2'b11);
        check("t5b_pops", pop_cnt - q0, 2);
        check("t5b_empty", empty, 1'b1);
        check("t5b_no_result", result, 4'h0);

        // 6: reset during POP_A, then 6 1 - END
        do_reset();
        send(1'b0, 1'b0, 4'd3);
        send(1'b0, 1'b0, 4'd4);
        send(1'b1, 1'b0, 4'd0);
        rst = 1'b0;
        #1;
        check("t6_err", err, 1'b0);
        check("t6_result", result, 4'h0);
        check("t6_ready", tok_ready, 1'b1);
        check("t6_push", push, 1'b0);
        check("t6_pop", pop, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("t6_empty", empty, 1'b1);
        send(1'b0, 1'b0, 4'd6);
        send(1'b0, 1'b0, 4'd1);
        send(1'b1, 1'b0, 4'd1);
        send(1'b0, 1'b1, 4'd0);
        wait_result("t6_final", 4'h5);
        check("t6_err_after", err, 1'b0);

        check("push_pop_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
